// File: rtl/syncfifo_pkg.sv
// syncfifo_pkg: pointer helpers shared by the synchronous FIFO read and
// write controllers. A pointer is {wrap bit, index}; the index runs
// 0..DEPTH-1 and each wrap toggles the wrap bit, so DEPTH need not be a
// power of two. Helpers work on 32-bit values; callers cast to their widths.
package syncfifo_pkg;

  // Index field of a pointer.
  function automatic int unsigned ptr_idx(input int unsigned ptr,
                                          input int unsigned idx_w);
    return ptr & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Wrap bit of a pointer.
  function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                           input int unsigned idx_w);
    return (ptr >> idx_w) & 32'd1;
  endfunction

  // Assemble a pointer from its fields.
  function automatic int unsigned ptr_make(input int unsigned wrap,
                                           input int unsigned idx,
                                           input int unsigned idx_w);
    return ((wrap & 32'd1) << idx_w) | idx;
  endfunction

  // ptr + k with wrap. k <= depth and idx < depth, so one subtraction
  // is enough to bring the index back into range.
  function automatic int unsigned ptr_add(input int unsigned ptr,
                                          input int unsigned k,
                                          input int unsigned depth,
                                          input int unsigned idx_w);
    int unsigned idx;
    int unsigned wrap;
    idx  = ptr_idx(ptr, idx_w) + k;
    wrap = ptr_wrap(ptr, idx_w);
    if (idx >= depth) begin
      idx  = idx - depth;
      wrap = wrap ^ 32'd1;
    end
    return ptr_make(wrap, idx, idx_w);
  endfunction

  // Occupancy between a write and a read pointer, 0..depth.
  function automatic int unsigned ptr_count(input int unsigned w_ptr,
                                            input int unsigned r_ptr,
                                            input int unsigned depth,
                                            input int unsigned idx_w);
    if (ptr_wrap(w_ptr, idx_w) == ptr_wrap(r_ptr, idx_w))
      return ptr_idx(w_ptr, idx_w) - ptr_idx(r_ptr, idx_w);
    else
      return depth - ptr_idx(r_ptr, idx_w) + ptr_idx(w_ptr, idx_w);
  endfunction

endpackage

// File: rtl/syncfifo_ptr_add.sv
// syncfifo_ptr_add: combinational wrap-aware pointer advance, ptr + k.
// Shared by the read and write controllers so both agree on encoding.
module syncfifo_ptr_add
  import syncfifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int PTR_W = IDX_W + 1,
  parameter int K_W   = 3
) (
  input  logic [PTR_W-1:0] ptr_i,
  input  logic [K_W-1:0]   k_i,
  output logic [PTR_W-1:0] sum_o
);

  assign sum_o = PTR_W'(ptr_add(32'(ptr_i), 32'(k_i), DEPTH, IDX_W));

endmodule

// File: rtl/syncfifo_rd_ctrl.sv
// syncfifo_rd_ctrl: read-side pointer controller for the synchronous FIFO.
// Grants up to MAX_POP entries per cycle (never more than are present),
// exports occupancy / empty / almost-empty, and flags underflow requests.
// Optional: SYNCFIFO_UNDERFLOW_STICKY_EN makes underflow a sticky flag
// cleared by err_clr; otherwise it is a one-cycle registered pulse.
module syncfifo_rd_ctrl
  import syncfifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int PTR_W     = IDX_W + 1,
  parameter int MAX_POP   = 4,
  parameter int POP_W     = $clog2(MAX_POP + 1),
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ren,
  input  logic [POP_W-1:0] pop_n,
  input  logic [PTR_W-1:0] w_ptr,
  input  logic             err_clr,
  output logic [PTR_W-1:0] r_ptr,
  output logic [IDX_W-1:0] r_addr,
  output logic [PTR_W-1:0] count,
  output logic             empty,
  output logic             almost_empty,
  output logic [POP_W-1:0] pop_ack,
  output logic             underflow
);

  logic [PTR_W-1:0] r_ptr_q;
  logic [PTR_W-1:0] r_ptr_d;
  logic             underflow_q;
  logic             underflow_d;
  logic [POP_W-1:0] req;
  logic             underflow_evt;

  // Occupancy, grant and underflow detection; all combinational.
  always_comb begin
    count = PTR_W'(ptr_count(32'(w_ptr), 32'(r_ptr_q), DEPTH, IDX_W));
    req   = (32'(pop_n) > MAX_POP) ? POP_W'(MAX_POP) : pop_n;
    underflow_evt = ren && (32'(req) > 32'(count));
    pop_ack = '0;
    if (ren) begin
      // Partial grant: never pop past the write pointer.
      pop_ack = (32'(req) > 32'(count)) ? POP_W'(count) : req;
    end
  end

  assign empty        = (count == '0);
  assign almost_empty = (32'(count) <= 32'(AE_THRESH));
  assign r_ptr        = r_ptr_q;
  assign r_addr       = r_ptr_q[IDX_W-1:0];
  assign underflow    = underflow_q;

  syncfifo_ptr_add #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .PTR_W (PTR_W),
    .K_W   (POP_W)
  ) u_ptr_add (
    .ptr_i (r_ptr_q),
    .k_i   (pop_ack),
    .sum_o (r_ptr_d)
  );

`ifdef SYNCFIFO_UNDERFLOW_STICKY_EN
  // Sticky flag: a new event wins over a simultaneous clear.
  always_comb begin
    underflow_d = underflow_evt || (underflow_q && !err_clr);
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  // Pulse flag: high for the single cycle after each event.
  always_comb begin
    underflow_d = underflow_evt;
  end
`endif

  // Pointer and error registers; reset discards any pending pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      r_ptr_q     <= r_ptr_d;
      underflow_q <= underflow_d;
    end
  end

  // With a non-power-of-two depth, some index encodings are illegal.
  if ((1 << IDX_W) != DEPTH) begin : g_idx_chk
    a_w_idx_legal: assert property (@(posedge clk) disable iff (!rst)
      32'(w_ptr[IDX_W-1:0]) < DEPTH);
  end

endmodule

// File: tb/tb_syncfifo_rd_ctrl.sv
// Directed bench for syncfifo_rd_ctrl: a DEPTH=16 and a DEPTH=12 instance
// share clock and reset. Expectations depend on SYNCFIFO_UNDERFLOW_STICKY_EN.
module tb_syncfifo_rd_ctrl;

`ifdef SYNCFIFO_UNDERFLOW_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic rst;

  // DEPTH=16 instance
  logic       ren16, err_clr16, empty16, ae16, uf16;
  logic [2:0] pop16, ack16;
  logic [4:0] w16, r16, cnt16;
  logic [3:0] addr16;

  // DEPTH=12 instance
  logic       ren12, err_clr12, empty12, ae12, uf12;
  logic [2:0] pop12, ack12;
  logic [4:0] w12, r12, cnt12;
  logic [3:0] addr12;

  int checks   = 0;
  int failures = 0;

  syncfifo_rd_ctrl #(.DEPTH(16), .MAX_POP(4), .AE_THRESH(2)) u_d16 (
    .clk(clk), .rst(rst), .ren(ren16), .pop_n(pop16), .w_ptr(w16),
    .err_clr(err_clr16), .r_ptr(r16), .r_addr(addr16), .count(cnt16),
    .empty(empty16), .almost_empty(ae16), .pop_ack(ack16), .underflow(uf16)
  );

  syncfifo_rd_ctrl #(.DEPTH(12), .MAX_POP(4), .AE_THRESH(2)) u_d12 (
    .clk(clk), .rst(rst), .ren(ren12), .pop_n(pop12), .w_ptr(w12),
    .err_clr(err_clr12), .r_ptr(r12), .r_addr(addr12), .count(cnt12),
    .empty(empty12), .almost_empty(ae12), .pop_ack(ack12), .underflow(uf12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ren16 = 1'b0; pop16 = '0; w16 = '0; err_clr16 = 1'b0;
    ren12 = 1'b0; pop12 = '0; w12 = '0; err_clr12 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (r16 !== 5'd0) begin failures++; $display("FAIL reset_rptr: got %0d expected 0", r16); end
    checks++; if (uf16 !== 1'b0) begin failures++; $display("FAIL reset_uf: got %0b expected 0", uf16); end
    checks++; if (empty16 !== 1'b1 || ae16 !== 1'b1) begin failures++; $display("FAIL reset_empty: got empty=%0b ae=%0b expected 1 1", empty16, ae16); end
    w16 = 5'd3; #1;
    checks++; if (cnt16 !== 5'd3 || empty16 !== 1'b0) begin failures++; $display("FAIL reset_count_follow: got count=%0d empty=%0b expected 3 0", cnt16, empty16); end
    $display("test_reset done");
  endtask

  task automatic test_pow2_pop();
    do_reset();
    w16 = 5'd5; ren16 = 1'b1; pop16 = 3'd2; #1;
    checks++; if (ack16 !== 3'd2) begin failures++; $display("FAIL pow2_ack0: got %0d expected 2", ack16); end
    tick();
    checks++; if (r16 !== 5'd2 || cnt16 !== 5'd3 || ack16 !== 3'd2 || ae16 !== 1'b0) begin failures++; $display("FAIL pow2_c1: got r=%0d cnt=%0d ack=%0d ae=%0b expected 2 3 2 0", r16, cnt16, ack16, ae16); end
    tick();
    checks++; if (r16 !== 5'd4 || cnt16 !== 5'd1 || ack16 !== 3'd1 || ae16 !== 1'b1 || uf16 !== 1'b0) begin failures++; $display("FAIL pow2_c2: got r=%0d cnt=%0d ack=%0d ae=%0b uf=%0b expected 4 1 1 1 0", r16, cnt16, ack16, ae16, uf16); end
    tick();
    checks++; if (r16 !== 5'd5 || empty16 !== 1'b1 || ack16 !== 3'd0 || uf16 !== 1'b1) begin failures++; $display("FAIL pow2_c3: got r=%0d empty=%0b ack=%0d uf=%0b expected 5 1 0 1", r16, empty16, ack16, uf16); end
    // The fourth request (2 against count 0) is itself an underflow event.
    tick();
    checks++; if (r16 !== 5'd5 || uf16 !== 1'b1) begin failures++; $display("FAIL pow2_c4: got r=%0d uf=%0b expected 5 1", r16, uf16); end
    ren16 = 1'b0;
    tick();
    checks++; if (uf16 !== STICKY) begin failures++; $display("FAIL pow2_uf_end: got %0b expected %0b", uf16, STICKY); end
    $display("test_pow2_pop done");
  endtask

  task automatic test_nonpow2_wrap();
    do_reset();
    w12 = 5'd10; ren12 = 1'b1; pop12 = 3'd4;
    tick(); tick();
    pop12 = 3'd2;
    tick();
    ren12 = 1'b0;
    checks++; if (r12 !== 5'd10) begin failures++; $display("FAIL np2_setup: got r=%0d expected 10", r12); end
    w12 = 5'b10011; #1;
    checks++; if (cnt12 !== 5'd5 || ae12 !== 1'b0) begin failures++; $display("FAIL np2_count: got cnt=%0d ae=%0b expected 5 0", cnt12, ae12); end
    ren12 = 1'b1; pop12 = 3'd4; #1;
    checks++; if (ack12 !== 3'd4) begin failures++; $display("FAIL np2_ack: got %0d expected 4", ack12); end
    tick();
    ren12 = 1'b0;
    checks++; if (r12 !== 5'b10010 || addr12 !== 4'd2) begin failures++; $display("FAIL np2_wrap_ptr: got r=%0d addr=%0d expected 18 2", r12, addr12); end
    checks++; if (cnt12 !== 5'd1 || ae12 !== 1'b1 || empty12 !== 1'b0 || uf12 !== 1'b0) begin failures++; $display("FAIL np2_status: got cnt=%0d ae=%0b empty=%0b uf=%0b expected 1 1 0 0", cnt12, ae12, empty12, uf12); end
    $display("test_nonpow2_wrap done");
  endtask

  task automatic test_full_boundary();
    do_reset();
    w12 = 5'b10000; #1;
    checks++; if (cnt12 !== 5'd12 || empty12 !== 1'b0 || ae12 !== 1'b0) begin failures++; $display("FAIL full: got cnt=%0d empty=%0b ae=%0b expected 12 0 0", cnt12, empty12, ae12); end
    ren12 = 1'b1; pop12 = 3'd4; #1;
    checks++; if (ack12 !== 3'd4) begin failures++; $display("FAIL full_ack: got %0d expected 4", ack12); end
    tick();
    ren12 = 1'b0;
    checks++; if (r12 !== 5'd4 || cnt12 !== 5'd8) begin failures++; $display("FAIL full_pop: got r=%0d cnt=%0d expected 4 8", r12, cnt12); end
    $display("test_full_boundary done");
  endtask

  task automatic test_clamp();
    do_reset();
    w16 = 5'd10; ren16 = 1'b1; pop16 = 3'd7; #1;
    checks++; if (ack16 !== 3'd4) begin failures++; $display("FAIL clamp_ack: got %0d expected 4", ack16); end
    tick();
    ren16 = 1'b0;
    checks++; if (r16 !== 5'd4 || cnt16 !== 5'd6 || uf16 !== 1'b0) begin failures++; $display("FAIL clamp_adv: got r=%0d cnt=%0d uf=%0b expected 4 6 0", r16, cnt16, uf16); end
    $display("test_clamp done");
  endtask

  task automatic test_underflow_flag();
    logic exp_uf;
    do_reset();
    w16 = 5'd0; ren16 = 1'b1; pop16 = 3'd1; #1;
    checks++; if (ack16 !== 3'd0) begin failures++; $display("FAIL uf_ack: got %0d expected 0", ack16); end
    tick();
    ren16 = 1'b0;
    checks++; if (uf16 !== 1'b1) begin failures++; $display("FAIL uf_set: got %0b expected 1", uf16); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_uf = STICKY;
      checks++; if (uf16 !== exp_uf) begin failures++; $display("FAIL uf_hold%0d: got %0b expected %0b", i, uf16, exp_uf); end
    end
    // Clear coinciding with a new event: the event wins in both modes.
    err_clr16 = 1'b1; ren16 = 1'b1; pop16 = 3'd1;
    tick();
    err_clr16 = 1'b0; ren16 = 1'b0;
    checks++; if (uf16 !== 1'b1) begin failures++; $display("FAIL uf_clr_vs_set: got %0b expected 1", uf16); end
    err_clr16 = 1'b1;
    tick();
    err_clr16 = 1'b0;
    checks++; if (uf16 !== 1'b0) begin failures++; $display("FAIL uf_clr: got %0b expected 0", uf16); end
    // ren with pop_n == 0 on an empty FIFO is a no-op.
    ren16 = 1'b1; pop16 = 3'd0; #1;
    checks++; if (ack16 !== 3'd0) begin failures++; $display("FAIL pop0_ack: got %0d expected 0", ack16); end
    tick();
    ren16 = 1'b0;
    checks++; if (uf16 !== 1'b0 || r16 !== 5'd0) begin failures++; $display("FAIL pop0_noop: got uf=%0b r=%0d expected 0 0", uf16, r16); end
    $display("test_underflow_flag done");
  endtask

  task automatic test_async_reset();
    do_reset();
    w16 = 5'd7; ren16 = 1'b1; pop16 = 3'd4;
    tick();
    tick();
    checks++; if (r16 !== 5'd7 || uf16 !== 1'b1) begin failures++; $display("FAIL arst_setup: got r=%0d uf=%0b expected 7 1", r16, uf16); end
    pop16 = 3'd2;
    #3 rst = 1'b0;
    #1;
    checks++; if (r16 !== 5'd0 || uf16 !== 1'b0) begin failures++; $display("FAIL arst_clear: got r=%0d uf=%0b expected 0 0", r16, uf16); end
    checks++; if (cnt16 !== 5'd7) begin failures++; $display("FAIL arst_count: got %0d expected 7", cnt16); end
    tick();
    checks++; if (r16 !== 5'd0) begin failures++; $display("FAIL arst_hold: got %0d expected 0", r16); end
    ren16 = 1'b0;
    rst = 1'b1;
    $display("test_async_reset done");
  endtask

  initial begin
    rst = 1'b0;
    ren16 = 1'b0; pop16 = '0; w16 = '0; err_clr16 = 1'b0;
    ren12 = 1'b0; pop12 = '0; w12 = '0; err_clr12 = 1'b0;
    test_reset();
    test_pow2_pop();
    test_nonpow2_wrap();
    test_full_boundary();
    test_clamp();
    test_underflow_flag();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
